// File: rtl/gascon_pkg.sv
// Shared definitions for the Gascon permutation controller.
//   CWIDTH       : permutation state width in bits
//   MAX_ROUNDS   : rounds in a full permutation
//   ctrl_state_e : controller FSM encoding
//   rc()         : round-constant byte used by reference models of the round block
package gascon_pkg;

    localparam int CWIDTH     = 320;
    localparam int MAX_ROUNDS = 12;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RRST,
        RWAIT,
        DONE
    } ctrl_state_e;

    // ((0xF - idx) << 4) | idx packs into a single byte.
    function automatic logic [7:0] rc(input logic [3:0] idx);
        logic [3:0] hi;
        hi = 4'hF - idx;
        return {hi, idx};
    endfunction

endpackage

// File: rtl/gascon_watchdog.sv
// Round-block stall watchdog.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : restart the count (issued once per round)
//   en         : count while a round is in flight
//   expire     : high during the TIMEOUT-th enabled cycle since the last clear
module gascon_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/gascon_perm_ctrl.sv
// Iterating controller for the single-round Gascon datapath.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start, nrounds,
//   state_in, ready       : request side; inputs sampled when ready=1
//   state_out, valid, ack : result side; valid held until ack
//   error                 : sticky watchdog flag, cleared by reset or next accepted start
//   rnd_state, rnd_idx,
//   rnd_reset             : drive the round block's c / round / reset inputs
//   rnd_done, rnd_result  : round block completion and output
module gascon_perm_ctrl #(
    parameter int CWIDTH     = gascon_pkg::CWIDTH,
    parameter int ROUND_W    = 16,
    parameter int MAX_ROUNDS = gascon_pkg::MAX_ROUNDS,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        nrounds,
    input  logic [CWIDTH-1:0] state_in,
    output logic              ready,
    output logic [CWIDTH-1:0] state_out,
    output logic              valid,
    input  logic              ack,
    output logic              error,
    output logic [CWIDTH-1:0] rnd_state,
    output logic [ROUND_W-1:0] rnd_idx,
    output logic              rnd_reset,
    input  logic              rnd_done,
    input  logic [CWIDTH-1:0] rnd_result
);

    import gascon_pkg::*;

    ctrl_state_e       state;
    logic [CWIDTH-1:0] st;
    logic [3:0]        eff;
    logic [3:0]        left;
    logic              wd_expire;
    logic [3:0]        eff_next;

    // Requests longer than a full permutation are clipped to it.
    assign eff_next = ({1'b0, nrounds} > 5'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : nrounds;

    gascon_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == RRST),
        .en     (state == RWAIT),
        .expire (wd_expire)
    );

    // Round block runs only while a round is in flight; reset forces it idle too.
    assign rnd_reset = reset | (state != RWAIT);
    assign rnd_state = st;
    assign state_out = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            valid   <= 1'b0;
            error   <= 1'b0;
            st      <= '0;
            rnd_idx <= '0;
            eff     <= '0;
            left    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        st    <= state_in;
                        error <= 1'b0;
                        eff   <= eff_next;
                        ready <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Shortened permutations run the final rounds of the schedule.
                    rnd_idx <= ROUND_W'(MAX_ROUNDS) - ROUND_W'(eff);
                    left    <= eff;
                    if (eff == 4'd0) begin
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RRST;
                    end
                end
                RRST: begin
                    state <= RWAIT;
                end
                RWAIT: begin
                    // A done arriving on the expiry cycle still completes the round.
                    if (rnd_done) begin
                        st      <= rnd_result;
                        rnd_idx <= rnd_idx + 1'b1;
                        left    <= left - 1'b1;
                        if (left == 4'd1) begin
                            valid <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= RRST;
                        end
                    end else if (wd_expire) begin
                        error <= 1'b1;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (ack) begin
                        valid <= 1'b0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
